// File: rtl/iter_shifter.sv
// Iterative one-bit-per-cycle shifter/rotator with an IDLE/SHIFT/DONE handshake.
// N must equal 2**W so that every amount 0..N-1 is representable in amt.
module iter_shifter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] din,
  input  logic [W-1:0] amt,
  input  logic         lr,
  input  logic         rot,
  output logic         ready,
  output logic         done_tick,
  output logic [N-1:0] dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [W-1:0] COUNT_ONE = W'(1);

  state_t       state_q;
  logic [N-1:0] data_q;
  logic [N-1:0] data_d;
  logic [N-1:0] dout_q;
  logic [W-1:0] count_q;
  logic         lr_q;
  logic         rot_q;

  // One-position move; the vacated bit is refilled from the opposite end only when rotating.
  function automatic logic [N-1:0] step_one(input logic [N-1:0] d,
                                            input logic         left,
                                            input logic         rotate);
    logic fill;
    if (left) begin
      fill     = rotate ? d[N-1] : 1'b0;
      step_one = {d[N-2:0], fill};
    end else begin
      fill     = rotate ? d[0] : 1'b0;
      step_one = {fill, d[N-1:1]};
    end
  endfunction

  // Next value of the working register for a single shift step
  always_comb begin
    data_d = step_one(data_q, lr_q, rot_q);
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      lr_q    <= 1'b0;
      rot_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            data_q  <= din;
            count_q <= amt;
            lr_q    <= lr;
            rot_q   <= rot;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          // Decrement only while nonzero so the count can never wrap.
          if (count_q != '0) begin
            data_q  <= data_d;
            count_q <= count_q - COUNT_ONE;
            state_q <= SHIFT;
          end else begin
            dout_q  <= data_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign dout      = dout_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: abstract timing/result model plus
// directed literal scenarios and randomized traffic with occasional resets.
module tb_iter_shifter;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] din = '0;
  logic [W-1:0] amt = '0;
  logic         lr = 1'b0;
  logic         rot = 1'b0;
  logic         ready;
  logic         done_tick;
  logic [N-1:0] dout;

  int checks = 0;
  int errors = 0;

  iter_shifter #(.N(N), .W(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .din(din), .amt(amt),
    .lr(lr), .rot(rot), .ready(ready), .done_tick(done_tick), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of the whole operation computed in one go from the shift rules.
  function automatic logic [N-1:0] ref_op(input logic [N-1:0] d, input int s,
                                          input logic l, input logic r);
    if (r) ref_op = l ? ((d << s) | (d >> (N - s))) : ((d >> s) | (d << (N - s)));
    else   ref_op = l ? (d << s) : (d >> s);
  endfunction

  // Model: an accepted op finishes exactly amt+2 cycles later; the unit is busy through that cycle.
  bit           m_busy = 1'b0;
  int           m_cyc = 0;
  int           m_done_at = 0;
  logic [N-1:0] m_res = '0;
  logic [N-1:0] m_dout = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0;
      m_dout = '0;
    end else begin
      if (!m_busy && start) begin
        m_busy    = 1'b1;
        m_done_at = m_cyc + int'(amt) + 2;
        m_res     = ref_op(din, int'(amt), lr, rot);
      end
      m_cyc++;
      if (m_busy && m_cyc == m_done_at) m_dout = m_res;
      if (m_busy && m_cyc == m_done_at + 1) m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("ready", 32'(ready), 32'(!m_busy));
    chk("done_tick", 32'(done_tick), 32'(m_busy && (m_cyc == m_done_at)));
    chk("dout", 32'(dout), 32'(m_dout));
  end

  task automatic run_op(input logic [N-1:0] d, input logic [W-1:0] a, input logic l,
                        input logic r, input bit noise, input logic [N-1:0] exp_dout,
                        input int exp_lat);
    int seen;
    int got_lat;
    logic [N-1:0] got;
    seen = 0;
    got_lat = -1;
    got = '0;
    @(posedge clk); #1;
    start = 1'b1; din = d; amt = a; lr = l; rot = r;
    @(negedge clk);
    chk("op_ready_at_start", 32'(ready), 32'd1);
    for (int k = 1; k <= exp_lat + 4; k++) begin
      @(posedge clk); #1;
      if (noise && k <= exp_lat) begin
        start = 1'b1; din = 8'hFF; amt = 3'd1; lr = ~l; rot = ~r;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k <= exp_lat) chk("op_busy", 32'(ready), 32'd0);
      if (done_tick) begin
        seen++;
        if (got_lat < 0) begin
          got_lat = k;
          got = dout;
        end
      end
    end
    chk("op_latency", 32'(got_lat), 32'(exp_lat));
    chk("op_done_count", 32'(seen), 32'd1);
    chk("op_result", 32'(got), 32'(exp_dout));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done_tick), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Hand-computed expectations pinning both the RTL and the model
    run_op(8'b1001_0110, 3'd3, 1'b1, 1'b1, 1'b0, 8'b1011_0100, 5);
    run_op(8'b1001_0110, 3'd3, 1'b0, 1'b0, 1'b0, 8'b0001_0010, 5);
    run_op(8'b1001_0110, 3'd3, 1'b1, 1'b0, 1'b0, 8'b1011_0000, 5);
    run_op(8'h81, 3'd7, 1'b0, 1'b1, 1'b0, 8'h03, 9);
    run_op(8'hA5, 3'd0, 1'b1, 1'b0, 1'b0, 8'hA5, 2);
    run_op(8'h01, 3'd4, 1'b1, 1'b1, 1'b1, 8'h10, 6);

    // Reset in the middle of an amt=5 operation
    @(posedge clk); #1;
    start = 1'b1; din = 8'h5A; amt = 3'd5; lr = 1'b1; rot = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_ready", 32'(ready), 32'd1);
    chk("midreset_done", 32'(done_tick), 32'd0);
    chk("midreset_dout", 32'(dout), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("postreset_no_done", 32'(done_tick), 32'd0);
    end

    // start held high, amt=1: results every 4 cycles
    @(posedge clk); #1;
    start = 1'b1; din = 8'h81; amt = 3'd1; lr = 1'b1; rot = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(ready), 32'((k % 4) == 0));
      chk("b2b_done", 32'(done_tick), 32'((k == 3) || (k == 7) || (k == 11)));
      if (done_tick) chk("b2b_dout", 32'(dout), 32'h03);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);

    // Randomized traffic with rare resets; the model checks every cycle
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      start   = ($urandom_range(0, 2) == 0);
      din     = 8'($urandom);
      amt     = 3'($urandom);
      lr      = 1'($urandom);
      rot     = 1'($urandom);
      reset_n = ($urandom_range(0, 149) != 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
